bist_sequencer: RTL and testbench

- Top-level BIST sequencer for the pattern-test datapath.
- Drives the LFSR pattern generator and MISR signature compactor through a fixed schedule of M_ROUNDS rounds of N_CYCLES patterns each.
- At the end of the schedule it compares the MISR signature against a golden value and holds a pass/fail verdict until the next start.
- Sits between the raw start pin and the LFSR/MISR/CUT-mux datapath; it owns all BIST enables.

---
 rtl/bist_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bist_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: BIST schedule controller for the LFSR/MISR pattern-test datapath.
// Runs M_ROUNDS rounds of N_CYCLES patterns, then checks the MISR signature against GOLDEN_SIG.
// Optional macro BIST_ABORT_EN adds an abort input that returns an active test to IDLE.
module bist_sequencer #(
  parameter int               N_CYCLES   = 16,
  parameter int               M_ROUNDS   = 12,
  parameter int               PAT_W      = 4,
  parameter int               RND_W      = 4,
  parameter int               SIG_W      = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SIG_W-1:0] misr_sig,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic             lfsr_seed_load,
  output logic             lfsr_en,
  output logic             misr_clear,
  output logic             misr_en,
  output logic             test_mode,
  output logic             round_done,
  output logic [RND_W-1:0] round_idx,
  output logic             running,
  output logic             bist_end,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_RUN     = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             start_q;
  logic [PAT_W-1:0] pat_cnt;
  logic             go;
  logic             last_pat;
  logic             last_rnd;
  logic             abort_hit;

  // Rising edge of the raw start level; a held level only triggers once.
  assign go       = start & ~start_q;
  assign last_pat = (pat_cnt == PAT_W'(N_CYCLES - 1));
  assign last_rnd = (round_idx == RND_W'(M_ROUNDS - 1));

`ifdef BIST_ABORT_EN
  // Abort only matters while a test is active; IDLE and DONE ignore it.
  assign abort_hit = abort & ((state == S_SEED) | (state == S_RUN) | (state == S_COMPARE));
`else
  assign abort_hit = 1'b0;
`endif

  // State register; an illegal encoding falls back to IDLE via next_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode for the test schedule.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (go) next_state = S_SEED;
      S_SEED:    next_state = S_RUN;
      S_RUN:     if (last_pat && last_rnd) next_state = S_COMPARE;
      S_COMPARE: next_state = S_DONE;
      S_DONE:    if (go) next_state = S_SEED;
      default:   next_state = S_IDLE;
    endcase
    if (abort_hit) next_state = S_IDLE;
  end

  // Registered copy of start for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Pattern and round counters; cleared on entry to SEED so a new test starts at round 0.
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      pat_cnt   <= '0;
      round_idx <= '0;
    end else if (next_state == S_SEED) begin
      pat_cnt   <= '0;
      round_idx <= '0;
    end else if (state == S_RUN) begin
      if (last_pat) begin
        pat_cnt <= '0;
        if (!last_rnd) round_idx <= round_idx + RND_W'(1);
      end else begin
        pat_cnt <= pat_cnt + PAT_W'(1);
      end
    end
  end

  // Verdict register: captured in COMPARE, held through DONE, cleared when a new test starts.
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (next_state == S_SEED) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state == S_COMPARE) begin
      pass <= (misr_sig == GOLDEN_SIG);
      fail <= (misr_sig != GOLDEN_SIG);
    end
  end

  // Moore output decode from the registered state and pattern counter.
  always_comb begin
    lfsr_seed_load = 1'b0;
    lfsr_en        = 1'b0;
    misr_clear     = 1'b0;
    misr_en        = 1'b0;
    test_mode      = 1'b0;
    round_done     = 1'b0;
    running        = 1'b0;
    bist_end       = 1'b0;
    case (state)
      S_SEED: begin
        lfsr_seed_load = 1'b1;
        misr_clear     = 1'b1;
        test_mode      = 1'b1;
        running        = 1'b1;
      end
      S_RUN: begin
        lfsr_en    = 1'b1;
        misr_en    = 1'b1;
        test_mode  = 1'b1;
        running    = 1'b1;
        round_done = last_pat;
      end
      S_COMPARE: begin
        test_mode = 1'b1;
        running   = 1'b1;
      end
      S_DONE: begin
        bist_end = 1'b1;
      end
      default: begin
        lfsr_seed_load = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer: directed steps with a scoreboard of expected
// round_done pulses and end-of-test verdicts, compared as the DUT produces them.
module tb_bist_sequencer;

  localparam int N = 16;
  localparam int M = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] misr_sig = 8'h00;
  logic       abort = 1'b0;
  logic       lfsr_seed_load, lfsr_en, misr_clear, misr_en, test_mode;
  logic       round_done, running, bist_end, pass, fail;
  logic [3:0] round_idx;

  bist_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .misr_sig       (misr_sig),
`ifdef BIST_ABORT_EN
    .abort          (abort),
`endif
    .lfsr_seed_load (lfsr_seed_load),
    .lfsr_en        (lfsr_en),
    .misr_clear     (misr_clear),
    .misr_en        (misr_en),
    .test_mode      (test_mode),
    .round_done     (round_done),
    .round_idx      (round_idx),
    .running        (running),
    .bist_end       (bist_end),
    .pass           (pass),
    .fail           (fail)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] ridx; } rd_exp_t;
  typedef struct { int cyc; logic pass; logic fail; } vd_exp_t;

  rd_exp_t rd_q[$];
  vd_exp_t vd_q[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  logic    bist_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] all_outs();
    return {lfsr_seed_load, lfsr_en, misr_clear, misr_en, test_mode, round_done,
            round_idx, running, bist_end, pass, fail};
  endfunction

  // Advance one cycle, then sample outputs and retire scoreboard entries.
  task automatic tick();
    rd_exp_t re;
    vd_exp_t ve;
    @(posedge clk);
    cyc++;
    #1;
    check("invariants", {pass & fail, running & bist_end, bist_end & ~(pass ^ fail)}, 3'b000);
    if (round_done) begin
      check("round_done_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        check("round_done_cycle", cyc, re.cyc);
        check("round_done_idx", round_idx, re.ridx);
      end
    end
    if (bist_end && !bist_prev) begin
      check("verdict_expected", vd_q.size() != 0, 1);
      if (vd_q.size() != 0) begin
        ve = vd_q.pop_front();
        check("done_cycle", cyc, ve.cyc);
        check("verdict", {pass, fail}, {ve.pass, ve.fail});
      end
    end
    bist_prev = bist_end;
  endtask

  // Start a test in the current cycle and follow it to DONE, optionally
  // glitching start, resetting or aborting at a given cycle offset.
  task automatic run_test(input logic [7:0] sig, input bit hold, input int glitch_at,
                          input int reset_at, input int abort_at);
    int  cs;
    int  en_cnt;
    int  first_en;
    bit  exp_pass;
    misr_sig = sig;
    exp_pass = (sig == 8'hA5);
    cs       = cyc;
    start    = 1'b1;
    for (int r = 0; r < M; r++) rd_q.push_back('{cs + 1 + N * (r + 1), 4'(r)});
    vd_q.push_back('{cs + 3 + N * M, exp_pass, !exp_pass});
    tick();
    check("seed_outputs", {lfsr_seed_load, misr_clear, test_mode, running, lfsr_en, pass, fail, round_idx},
          {7'b1111000, 4'd0});
    if (!hold) start = 1'b0;
    en_cnt   = 0;
    first_en = -1;
    for (int i = 1; i < N * M + 3; i++) begin
      if (i == glitch_at) start = 1'b1;
      else if (i == glitch_at + 1) start = 1'b0;
      if (i == reset_at) reset = 1'b1;
      if (i == abort_at) abort = 1'b1;
      tick();
      if (i == reset_at || i == abort_at) begin
        check("interrupt_outputs_zero", all_outs(), 14'd0);
        reset = 1'b0;
        abort = 1'b0;
        rd_q.delete();
        vd_q.delete();
        return;
      end
      if (lfsr_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc - cs;
      end
    end
    check("lfsr_en_cycles", en_cnt, N * M);
    check("lfsr_en_first_offset", first_en, 2);
    check("done_outputs", {bist_end, running, test_mode, lfsr_en, pass, fail},
          {3'b100, 1'b0, exp_pass, !exp_pass});
    check("scoreboard_drained", rd_q.size() + vd_q.size(), 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("reset_outputs_zero", all_outs(), 14'd0);
    tick();
    check("idle_outputs_zero", all_outs(), 14'd0);

    // Basic run with matching signature
    run_test(8'hA5, 1'b0, -10, -10, -10);
    tick();
    check("done_held_pass", {bist_end, pass, fail}, 3'b110);

    // Mismatch run; SEED clears the previous pass
    run_test(8'h00, 1'b0, -10, -10, -10);
    tick();
    check("done_held_fail", {bist_end, pass, fail}, 3'b101);

    // Start held high: exactly one test, then stays in DONE
    run_test(8'hA5, 1'b1, -10, -10, -10);
    for (int i = 0; i < 500 - (N * M + 3); i++) tick();
    check("held_start_stays_done", {bist_end, running, pass, fail}, 4'b1010);
    start = 1'b0;
    tick();
    tick();

    // Re-raise: new run; pass clears in SEED, verdict now fail
    run_test(8'h3C, 1'b0, -10, -10, -10);
    tick();

    // Start pulse during RUN is ignored
    run_test(8'hA5, 1'b0, 50, -10, -10);
    tick();

    // Reset during RUN
    run_test(8'hA5, 1'b0, -10, 100, -10);
    check("after_reset_round_idx", round_idx, 4'd0);
    tick();
    check("after_reset_idle", all_outs(), 14'd0);

    // Normal run after reset
    run_test(8'h00, 1'b0, -10, -10, -10);
    tick();

`ifdef BIST_ABORT_EN
    // Abort during RUN, then a full run completes
    run_test(8'hA5, 1'b0, -10, -10, 60);
    tick();
    check("after_abort_idle", all_outs(), 14'd0);
    run_test(8'hA5, 1'b0, -10, -10, -10);
    tick();
`endif

    check("final_scoreboard_empty", rd_q.size() + vd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
